// File: rtl/spiking_array_scheduler.sv
// Timestep sequencer for a ROWS x COLS systolic array of spiking PEs.
// Each timestep fetches one spike vector, injects it into the rows with
// systolic skew, waits for the array to drain, then strobes fire.

// Per-row injection: row r receives its latched spike only on skew slot r.
module spiking_row_inject #(
  parameter int CNT_W = 3,
  parameter int ROW   = 0
) (
  input  logic             en,
  input  logic             spk,
  input  logic [CNT_W-1:0] cnt,
  output logic             inj
);
  assign inj = en & spk & (cnt == CNT_W'(ROW));
endmodule

module spiking_array_scheduler #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] cfg_num_steps,
  input  logic              spk_valid,
  input  logic [ROWS-1:0]   spk_data,
  output logic              spk_ready,
  output logic [ROWS-1:0]   array_in_row,
  output logic              array_clear,
  output logic              array_fire,
  output logic [STEP_W-1:0] step_idx,
  output logic              busy,
  output logic              done
);
  localparam int LAST  = ROWS + COLS - 2;
  localparam int CNT_W = $clog2(ROWS + COLS);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT, S_INTEG, S_FIRE, S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [STEP_W-1:0] n_steps;
  logic [ROWS-1:0]   spk_lat;
  logic              abort_hit, last_step, cnt_last, in_integ;

  // abort only counts once an inference is running; in IDLE start wins
  assign abort_hit = abort && (state != S_IDLE);
  assign last_step = (step_idx == n_steps - STEP_W'(1));
  assign cnt_last  = (cnt == CNT_W'(LAST));

  // Next-state and Moore output decode
  always_comb begin
    state_nx    = state;
    spk_ready   = 1'b0;
    array_clear = 1'b0;
    array_fire  = 1'b0;
    done        = 1'b0;
    in_integ    = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE:  if (start) state_nx = S_CLEAR;
      S_CLEAR: begin
        array_clear = 1'b1;
        state_nx    = (n_steps == '0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        spk_ready = 1'b1;
        if (spk_valid) state_nx = S_INTEG;
      end
      S_INTEG: begin
        in_integ = 1'b1;
        if (cnt_last) state_nx = S_FIRE;
      end
      S_FIRE: begin
        array_fire = 1'b1;
        state_nx   = last_step ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // abort overrides every transition, FIRE->DONE included
    if (abort_hit) state_nx = S_IDLE;
  end

  // State register plus step/skew counters; an abort freezes the datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      step_idx <= '0;
      spk_lat  <= '0;
      n_steps  <= '0;
    end else begin
      state <= state_nx;
      if (!abort_hit) begin
        case (state)
          S_IDLE:  if (start) n_steps <= cfg_num_steps;
          S_CLEAR: step_idx <= '0;
          S_WAIT: if (spk_valid) begin
            spk_lat <= spk_data;
            cnt     <= '0;
          end
          S_INTEG: cnt <= cnt + CNT_W'(1);
          S_FIRE:  if (!last_step) step_idx <= step_idx + STEP_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Skewed row injection, one lane per array row
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    spiking_row_inject #(.CNT_W(CNT_W), .ROW(r)) u_row (
      .en  (in_integ),
      .spk (spk_lat[r]),
      .cnt (cnt),
      .inj (array_in_row[r])
    );
  end
endmodule

// File: tb/tb_spiking_array_scheduler.sv
// Scoreboard bench: each inference is planned as a cycle timeline from the
// scheduling rules, expected outputs are queued per cycle, and a monitor
// compares DUT outputs against the queue on the falling edge.
module tb_spiking_array_scheduler;
  localparam int ROWS = 4, COLS = 4, STEP_W = 8;
  localparam int ILEN = ROWS + COLS - 1;

  logic clk = 1'b0;
  logic rst, start, abort, spk_valid;
  logic [STEP_W-1:0] cfg_num_steps;
  logic [ROWS-1:0]   spk_data;
  logic              spk_ready, array_clear, array_fire, busy, done;
  logic [ROWS-1:0]   array_in_row;
  logic [STEP_W-1:0] step_idx;

  spiking_array_scheduler #(.ROWS(ROWS), .COLS(COLS), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_num_steps(cfg_num_steps), .spk_valid(spk_valid), .spk_data(spk_data),
    .spk_ready(spk_ready), .array_in_row(array_in_row), .array_clear(array_clear),
    .array_fire(array_fire), .step_idx(step_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ready, clear, fire, done, busy;
    logic [ROWS-1:0]   row;
    logic [STEP_W-1:0] step;
  } obs_t;
  typedef struct { int cyc; obs_t o; } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0, errors = 0;
  bit   end_chk = 0, mon_done = 0;
  logic [STEP_W-1:0] prev_step = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mk(logic rd, logic cl, logic fi, logic dn, logic bz,
                              logic [ROWS-1:0] row, logic [STEP_W-1:0] st);
    obs_t o;
    o = '{ready: rd, clear: cl, fire: fi, done: dn, busy: bz, row: row, step: st};
    return o;
  endfunction

  // Monitor: compare the output bundle whenever a cycle has an expectation
  always @(negedge clk) begin
    exp_t x;
    obs_t a;
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      x = sbq.pop_front();
      a = mk(spk_ready, array_clear, array_fire, done, busy, array_in_row, step_idx);
      checks++;
      if (a !== x.o)
        $display("FAIL outputs cyc=%0d got rdy=%b clr=%b fire=%b done=%b busy=%b row=%b step=%0d want rdy=%b clr=%b fire=%b done=%b busy=%b row=%b step=%0d",
          cyc, a.ready, a.clear, a.fire, a.done, a.busy, a.row, a.step,
          x.o.ready, x.o.clear, x.o.fire, x.o.done, x.o.busy, x.o.row, x.o.step);
      if (a !== x.o) errors++;
    end
    if (end_chk && !mon_done) begin
      checks++;
      if (sbq.size() != 0) begin
        errors++;
        $display("FAIL drain got %0d pending expectations want 0", sbq.size());
      end
      mon_done = 1;
    end
  end

  // Plan one inference from the rules, queue expectations, then drive it.
  // cut_at > 0 aborts (or resets, if use_rst) on that relative cycle.
  task automatic run_inf(input int n, input int stall_step, input int stall_len,
                         input int cut_at, input bit use_rst, input bit repulse,
                         input logic [ROWS-1:0] vec_fixed, input bit fixed, input bit rnd_stall);
    obs_t e[$];
    logic dv[$];
    logic [ROWS-1:0] dd[$];
    logic [ROWS-1:0] vec;
    logic [STEP_W-1:0] fin, hold;
    int stall, t0;
    e.push_back(mk(0, 0, 0, 0, 0, '0, prev_step));
    dv.push_back(1'($urandom_range(0, 1))); dd.push_back(ROWS'($urandom));
    e.push_back(mk(0, 1, 0, 0, 1, '0, prev_step));
    dv.push_back(1'($urandom_range(0, 1))); dd.push_back(ROWS'($urandom));
    for (int s = 0; s < n; s++) begin
      stall = (s == stall_step) ? stall_len : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
      vec = fixed ? vec_fixed : ROWS'($urandom);
      for (int k = 0; k < stall; k++) begin
        e.push_back(mk(1, 0, 0, 0, 1, '0, STEP_W'(s)));
        dv.push_back(1'b0); dd.push_back(ROWS'($urandom));
      end
      e.push_back(mk(1, 0, 0, 0, 1, '0, STEP_W'(s)));
      dv.push_back(1'b1); dd.push_back(vec);
      for (int c = 0; c < ILEN; c++) begin
        e.push_back(mk(0, 0, 0, 0, 1, (c < ROWS) ? (vec & ROWS'(1 << c)) : '0, STEP_W'(s)));
        dv.push_back(1'($urandom_range(0, 1))); dd.push_back(ROWS'($urandom));
      end
      e.push_back(mk(0, 0, 1, 0, 1, '0, STEP_W'(s)));
      dv.push_back(1'($urandom_range(0, 1))); dd.push_back(ROWS'($urandom));
    end
    fin = (n == 0) ? '0 : STEP_W'(n - 1);
    e.push_back(mk(0, 0, 0, 1, 1, '0, fin));
    dv.push_back(1'($urandom_range(0, 1))); dd.push_back(ROWS'($urandom));
    e.push_back(mk(0, 0, 0, 0, 0, '0, fin));
    dv.push_back(1'($urandom_range(0, 1))); dd.push_back(ROWS'($urandom));
    if (cut_at > 0 && cut_at < e.size() - 1) begin
      hold = use_rst ? '0 : e[cut_at].step;
      while (e.size() > cut_at + 1) void'(e.pop_back());
      e.push_back(mk(0, 0, 0, 0, 0, '0, hold));
      fin = hold;
    end else begin
      cut_at = -1;
    end
    prev_step = fin;
    t0 = cyc;
    for (int i = 0; i < e.size(); i++) sbq.push_back('{cyc: t0 + i, o: e[i]});
    for (int i = 0; i < e.size(); i++) begin
      start         = (i == 0) || (repulse && e[i].busy && $urandom_range(0, 2) == 0);
      cfg_num_steps = (i == 0) ? STEP_W'(n) : STEP_W'($urandom);
      abort         = (i == cut_at && !use_rst) || (i == 0 && $urandom_range(0, 1) == 1);
      rst           = (i == cut_at && use_rst);
      spk_valid     = dv[i];
      spk_data      = dd[i];
      @(posedge clk); #1;
    end
    start = 0; abort = 0; rst = 0; spk_valid = 0;
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; spk_valid = 0; spk_data = '0; cfg_num_steps = '0;
    repeat (3) @(posedge clk);
    #1;
    sbq.push_back('{cyc: cyc, o: mk(0, 0, 0, 0, 0, '0, '0)});
    @(posedge clk); #1;
    rst = 0;
    // basic two-step run with a fixed vector and no stalls
    run_inf(2, -1, 0, 0, 0, 0, 4'b1011, 1, 0);
    // five-cycle input stall in step 1
    run_inf(3, 1, 5, 0, 0, 0, '0, 0, 0);
    // zero-step inference: CLEAR then DONE
    run_inf(0, -1, 0, 0, 0, 0, '0, 0, 0);
    // abort during INTEG of step 1, then a clean restart
    run_inf(4, -1, 0, 14, 0, 0, '0, 0, 0);
    run_inf(2, -1, 0, 0, 0, 0, '0, 0, 0);
    // start re-pulsed while busy
    run_inf(9, -1, 0, 0, 0, 1, '0, 0, 1);
    // reset while in FIRE of step 0
    run_inf(2, -1, 0, 10, 1, 0, '0, 0, 0);
    run_inf(1, -1, 0, 0, 0, 0, '0, 0, 0);
    // randomized inferences with random stalls, aborts and resets
    for (int t = 0; t < 25; t++) begin
      int n, k;
      n = $urandom_range(0, 5);
      k = $urandom_range(0, 5);
      run_inf(n, -1, 0, (k <= 1) ? int'($urandom_range(1, 2 + n * 12)) : 0,
              (k == 1), $urandom_range(0, 1), '0, 0, 1);
    end
    end_chk = 1;
    for (int w = 0; w < 10 && !mon_done; w++) @(posedge clk);
    if (!mon_done) begin
      $display("FAIL monitor_end got timeout want drain check");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    end else begin
      $display("CHECKS %0d ERRORS %0d", checks, errors);
    end
    $finish;
  end
endmodule
